// File: rtl/log_reader.sv
// log_reader: sweeps the full logger BRAM pair and streams each 32-bit word MSB-byte first over valid/ready
// Ports: i_start/i_abort/i_mem_full control a dump; o_read_log/o_addr_log/i_data_log drive the logger read side;
// o_byte/o_byte_valid/i_byte_ready form the byte stream; o_busy/o_done/o_aborted report dump status.
module log_reader #(
  parameter int ADDR_WIDTH = 15,
  parameter int WORD_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_mem_full,
  output logic                  o_read_log,
  output logic [ADDR_WIDTH-1:0] o_addr_log,
  input  logic [WORD_WIDTH-1:0] i_data_log,
  output logic [7:0]            o_byte,
  output logic                  o_byte_valid,
  input  logic                  i_byte_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_aborted
);
  typedef enum logic [2:0] {IDLE, ARM, FETCH, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q;
  logic [1:0] idx_q;
  logic [WORD_WIDTH-1:0] word_q;
  logic abort, xfer, last_fetch, last_byte, last_addr;
  // a dropped full flag means the logger left its read state, so it is treated exactly like i_abort
  assign abort = (state_q != IDLE) && (i_abort || !i_mem_full);
  assign xfer = (state_q == SEND) && i_byte_ready;
  assign last_fetch = cnt_q == 4'(RD_LATENCY - 1);
  assign last_byte = idx_q == 2'd0;
  assign last_addr = &o_addr_log;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (i_start && i_mem_full) ? ARM : IDLE;
      ARM:     state_d = FETCH;
      FETCH:   state_d = last_fetch ? SEND : FETCH;
      SEND:    state_d = (xfer && last_byte) ? (last_addr ? DONE : FETCH) : SEND;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      o_addr_log <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      o_aborted  <= 1'b0;
    end else begin
      state_q   <= state_d;
      o_aborted <= abort;
      cnt_q     <= (state_q == FETCH) ? cnt_q + 4'd1 : 4'd0;
      // idle clears the address so ARM always presents address 0; the last address is held through DONE
      if (state_q == IDLE) o_addr_log <= '0;
      else if (xfer && last_byte && !last_addr && !abort) o_addr_log <= o_addr_log + 1'b1;
      if (state_q == FETCH && last_fetch) begin
        word_q <= i_data_log;
        idx_q  <= 2'd3;
      end else if (xfer) begin
        idx_q <= idx_q - 2'd1;
      end
    end
  end
  assign o_byte       = word_q[{idx_q, 3'b000} +: 8];
  assign o_byte_valid = state_q == SEND;
  assign o_read_log   = state_q != IDLE;
  assign o_busy       = state_q != IDLE;
  assign o_done       = state_q == DONE;
endmodule

// File: tb/tb_log_reader.sv
// tb_log_reader: randomized self-checking bench for log_reader against a queue-based byte-stream model
module tb_log_reader;
  localparam int AW = 3;
  localparam int RL = 2;
  logic clk = 1'b0;
  logic i_rst_n, i_start, i_abort, i_mem_full, i_byte_ready;
  logic o_read_log, o_byte_valid, o_busy, o_done, o_aborted;
  logic [AW-1:0] o_addr_log;
  logic [31:0] i_data_log;
  logic [7:0] o_byte;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  log_reader #(.ADDR_WIDTH(AW), .WORD_WIDTH(32), .RD_LATENCY(RL)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort), .i_mem_full(i_mem_full),
    .o_read_log(o_read_log), .o_addr_log(o_addr_log), .i_data_log(i_data_log),
    .o_byte(o_byte), .o_byte_valid(o_byte_valid), .i_byte_ready(i_byte_ready),
    .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted)
  );
  // registered memory: a word is only correct once the address has been held for RL cycles
  always_ff @(posedge clk) i_data_log <= {16'hA000 + {13'b0, o_addr_log}, 16'h5000 + {13'b0, o_addr_log}};
  function automatic void build_exp();
    exp_q.delete();
    for (int a = 0; a < (1 << AW); a++) begin
      logic [31:0] w;
      w = {16'hA000 + 16'(a), 16'h5000 + 16'(a)};
      for (int b = 3; b >= 0; b--) exp_q.push_back(8'(w >> (8 * b)));
    end
  endfunction
  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++) if (i >= got.size() || got[i] !== exp_q[i]) return i;
    return (got.size() == exp_q.size()) ? -1 : exp_q.size();
  endfunction
  task automatic run_dump(input int pct, input bit poke, output int nx, output int ndone,
                          output int nstall, output int t_first, output int t_done);
    logic [7:0] held;
    logic held_v;
    got.delete();
    nx = 0; ndone = 0; nstall = 0; t_first = -1; t_done = -1; held_v = 1'b0; held = '0;
    @(negedge clk);
    i_start = 1'b1;
    for (int cyc = 1; cyc < 3000 && t_done < 0; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (held_v && (!o_byte_valid || o_byte !== held)) nstall++;
      if (o_byte_valid && t_first < 0) t_first = cyc;
      if (o_done) begin ndone++; t_done = cyc; end
      if (poke && cyc == 10) i_start = 1'b1;
      i_byte_ready = (int'($urandom_range(99)) < pct);
      held_v = o_byte_valid && !i_byte_ready;
      held = o_byte;
      if (o_byte_valid && i_byte_ready) begin got.push_back(o_byte); nx++; end
    end
    i_byte_ready = 1'b1;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({o_read_log, o_addr_log, o_byte, o_byte_valid, o_busy, o_done, o_aborted} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got read=%b addr=%0d byte=%h valid=%b busy=%b done=%b abort=%b, expected all 0",
               o_read_log, o_addr_log, o_byte, o_byte_valid, o_busy, o_done, o_aborted);
    end
    i_rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_full_dump();
    int nx, nd, ns, tf, td, d;
    run_dump(100, 1'b0, nx, nd, ns, tf, td);
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL full_order: first bad byte index %0d (got %0d bytes), expected none", d, got.size()); end
    tests++; if (tf != 4) begin fails++; $display("FAIL full_first_valid: got cycle %0d expected 4", tf); end
    tests++; if (td != 50) begin fails++; $display("FAIL full_done_cycle: got cycle %0d expected 50", td); end
    tests++; if (nx != 32) begin fails++; $display("FAIL full_xfers: got %0d expected 32", nx); end
    tests++; if (nd != 1) begin fails++; $display("FAIL full_done_count: got %0d expected 1", nd); end
    @(negedge clk);
    tests++; if (o_busy !== 1'b0 || o_read_log !== 1'b0) begin fails++; $display("FAIL full_busy_fall: got busy=%b read=%b expected 0 0", o_busy, o_read_log); end
  endtask
  task automatic test_backpressure();
    int nx, nd, ns, tf, td, d;
    for (int r = 0; r < 2; r++) begin
      run_dump(40, 1'b0, nx, nd, ns, tf, td);
      d = first_diff();
      tests++; if (d != -1) begin fails++; $display("FAIL bp_order run %0d: first bad byte index %0d expected none", r, d); end
      tests++; if (ns != 0) begin fails++; $display("FAIL bp_stall_stable run %0d: got %0d unstable stalls expected 0", r, ns); end
      tests++; if (nx != 32) begin fails++; $display("FAIL bp_xfers run %0d: got %0d expected 32", r, nx); end
      tests++; if (nd != 1) begin fails++; $display("FAIL bp_done_count run %0d: got %0d expected 1", r, nd); end
      @(negedge clk);
    end
  endtask
  task automatic test_start_rejected();
    int bad;
    bad = 0;
    i_mem_full = 1'b0;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (o_busy || o_read_log || o_byte_valid) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL start_rejected: got %0d busy cycles expected 0", bad); end
    i_mem_full = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_start_busy();
    int nx, nd, ns, tf, td, d;
    run_dump(100, 1'b1, nx, nd, ns, tf, td);
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL busy_order: first bad byte index %0d expected none", d); end
    tests++; if (nx != 32) begin fails++; $display("FAIL busy_xfers: got %0d expected 32", nx); end
    tests++; if (nd != 1) begin fails++; $display("FAIL busy_done_count: got %0d expected 1", nd); end
    @(negedge clk);
  endtask
  task automatic test_abort_final();
    int nx, nd, ns, tf, td, d, k, dones;
    logic [7:0] last_b;
    k = 0; dones = 0; last_b = '0;
    @(negedge clk);
    i_start = 1'b1;
    for (int cyc = 0; cyc < 500 && !i_abort; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_done) dones++;
      if (o_byte_valid) begin
        if (k == 23) begin i_abort = 1'b1; last_b = o_byte; end
        k++;
      end
    end
    tests++; if (!i_abort) begin fails++; $display("FAIL abort_reach: got %0d transfers expected 24", k); end
    @(negedge clk);
    i_abort = 1'b0;
    tests++; if (last_b !== 8'h05) begin fails++; $display("FAIL abort_last_byte: got %h expected 05", last_b); end
    tests++; if (o_aborted !== 1'b1) begin fails++; $display("FAIL abort_pulse: got %b expected 1", o_aborted); end
    tests++; if (o_byte_valid !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL abort_idle: got valid=%b busy=%b expected 0 0", o_byte_valid, o_busy); end
    if (o_done) dones++;
    repeat (3) begin @(negedge clk); if (o_done) dones++; end
    tests++; if (dones != 0 || o_aborted !== 1'b0) begin fails++; $display("FAIL abort_no_done: got done=%0d aborted=%b expected 0 0", dones, o_aborted); end
    run_dump(100, 1'b0, nx, nd, ns, tf, td);
    d = first_diff();
    tests++; if (d != -1 || tf != 4) begin fails++; $display("FAIL abort_restart: got first bad %0d first valid %0d expected -1 4", d, tf); end
    @(negedge clk);
  endtask
  task automatic test_abort_fetch();
    bit hit;
    hit = 1'b0;
    @(negedge clk);
    i_start = 1'b1;
    for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_busy && !o_byte_valid && o_addr_log == 3'd2) begin i_mem_full = 1'b0; hit = 1'b1; end
    end
    @(negedge clk);
    i_mem_full = 1'b1;
    tests++; if (!hit || o_aborted !== 1'b1 || o_busy !== 1'b0) begin fails++; $display("FAIL fetch_abort: got hit=%b aborted=%b busy=%b expected 1 1 0", hit, o_aborted, o_busy); end
    @(negedge clk);
    tests++; if (o_aborted !== 1'b0 || o_done !== 1'b0) begin fails++; $display("FAIL fetch_abort_pulse_width: got aborted=%b done=%b expected 0 0", o_aborted, o_done); end
  endtask
  task automatic test_reset_mid();
    int bad;
    bad = 0;
    @(negedge clk);
    i_start = 1'b1;
    for (int cyc = 0; cyc < 500 && !o_byte_valid; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    @(negedge clk);
    i_rst_n = 1'b0;
    #1;
    tests++;
    if ({o_read_log, o_addr_log, o_byte, o_byte_valid, o_busy, o_done, o_aborted} !== '0) begin
      fails++;
      $display("FAIL reset_mid: got read=%b addr=%0d byte=%h valid=%b busy=%b done=%b abort=%b, expected all 0",
               o_read_log, o_addr_log, o_byte, o_byte_valid, o_busy, o_done, o_aborted);
    end
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (o_done || o_aborted || o_busy) bad++; end
    tests++; if (bad != 0) begin fails++; $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", bad); end
  endtask
  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_mem_full = 1'b1; i_byte_ready = 1'b1;
    build_exp();
    test_reset();
    test_full_dump();
    test_backpressure();
    test_start_rejected();
    test_start_busy();
    test_abort_final();
    test_abort_fetch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
